// File: rtl/key_check_array.sv
// ---------------------------------------------------------------------------
// key_check_array
// Multi-channel push-button conditioner. Each channel is synchronised,
// debounced, and turned into press / release / long-press / auto-repeat
// pulses. All channels share one free-running 1 ms tick, so the per-channel
// debounce and hold counters count milliseconds rather than clocks.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   i_key          raw asynchronous key pins
//   o_key          debounced level per channel, 1 = pressed
//   o_key_press    1-cycle pulse when the debounced level rises
//   o_key_release  1-cycle pulse when the debounced level falls
//   o_key_long     1-cycle pulse when a press has lasted LONG_MS
//   o_key_repeat   1-cycle pulse every REPEAT_MS after a long press
//                  (REPEAT_MS = 0 disables repeats)
//
// Event FSM (per channel)
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | key released, waiting for the debounced level to rise
//   ST_PRESSED | key down, counting ms towards the long-press threshold
//   ST_HELD    | long press reported, counting ms between repeat pulses
// ---------------------------------------------------------------------------
module key_check_array #(
   parameter int CLK_FRAC    = 50,
   parameter int KEY_NUM     = 4,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_NUM-1:0] i_key,
   output logic [KEY_NUM-1:0] o_key,
   output logic [KEY_NUM-1:0] o_key_press,
   output logic [KEY_NUM-1:0] o_key_release,
   output logic [KEY_NUM-1:0] o_key_long,
   output logic [KEY_NUM-1:0] o_key_repeat
);

   // -----------------------------------------------------------------------
   // Derived sizes
   // -----------------------------------------------------------------------
   localparam int TICK_CYC = CLK_FRAC * 1000;
   localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   // Debounce counter holds 0 .. DEBOUNCE_MS-1.
   localparam int DB_W     = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

   // Hold counter is shared between the long-press and repeat phases, so it
   // is sized for the larger of the two terminal counts.
   localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   localparam bit REPEAT_EN  = (REPEAT_MS != 0);
   localparam int REP_LAST_I = REPEAT_EN ? (REPEAT_MS - 1) : 0;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_LAST_I);

   // Pin level of a released key; the synchroniser resets to this so that
   // leaving reset never looks like an edge.
   localparam logic [KEY_NUM-1:0] KEY_IDLE = {KEY_NUM{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   // -----------------------------------------------------------------------
   // Shared 1 ms tick: down-counter style terminal-count compare on an
   // up-counter, one-cycle pulse at the terminal value.
   // -----------------------------------------------------------------------
   logic [TICK_W-1:0] r_tick_cnt;
   logic              w_tick;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Two-flop synchroniser for all pins, then polarity normalisation so that
   // w_raw_n = 1 always means "pressed".
   // -----------------------------------------------------------------------
   logic [KEY_NUM-1:0] r_sync1;
   logic [KEY_NUM-1:0] r_sync2;
   logic [KEY_NUM-1:0] w_raw_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= KEY_IDLE;
         r_sync2 <= KEY_IDLE;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
      end
   end

   assign w_raw_n = r_sync2 ^ KEY_IDLE;

   // -----------------------------------------------------------------------
   // Per-channel debounce and event FSM
   // -----------------------------------------------------------------------
   for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch

      logic              r_key;
      logic [DB_W-1:0]   r_db_cnt;
      logic              w_db_diff;
      logic              w_db_hit;
      logic              w_db_rise;
      logic              w_db_fall;

      state_t            r_state;
      state_t            w_state_nxt;
      logic [HOLD_W-1:0] r_hold_cnt;
      logic [HOLD_W-1:0] w_hold_nxt;

      logic              r_press;
      logic              r_release;
      logic              r_long;
      logic              r_repeat;
      logic              w_press_nxt;
      logic              w_release_nxt;
      logic              w_long_nxt;
      logic              w_repeat_nxt;

      // The debounced level flips on the DEBOUNCE_MS-th tick of a
      // continuous disagreement; any agreement restarts the count.
      assign w_db_diff = (w_raw_n[g] != r_key);
      assign w_db_hit  = w_db_diff && w_tick && (r_db_cnt == DB_LAST);
      assign w_db_rise = w_db_hit && !r_key;
      assign w_db_fall = w_db_hit &&  r_key;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_key    <= 1'b0;
            r_db_cnt <= '0;
         end else if (!w_db_diff) begin
            r_db_cnt <= '0;
         end else if (w_tick) begin
            if (r_db_cnt == DB_LAST) begin
               r_key    <= ~r_key;
               r_db_cnt <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end
      end

      // FSM state and registered pulse outputs
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
         end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
         end
      end

      // Next-state logic. It reacts to the debounce flip in the cycle it is
      // decided, so press/release pulses register on the same edge that
      // o_key changes. A falling level is checked before any tick work, so
      // a long or repeat pulse due in the release cycle is dropped.
      always_comb begin
         w_state_nxt   = r_state;
         w_hold_nxt    = r_hold_cnt;
         w_press_nxt   = 1'b0;
         w_release_nxt = 1'b0;
         w_long_nxt    = 1'b0;
         w_repeat_nxt  = 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_db_rise) begin
                  w_press_nxt = 1'b1;
                  w_hold_nxt  = '0;
                  w_state_nxt = ST_PRESSED;
               end
            end

            ST_PRESSED: begin
               if (w_db_fall) begin
                  w_release_nxt = 1'b1;
                  w_state_nxt   = ST_IDLE;
               end else if (w_tick) begin
                  if (r_hold_cnt == LONG_LAST) begin
                     w_long_nxt  = 1'b1;
                     w_hold_nxt  = '0;
                     w_state_nxt = ST_HELD;
                  end else begin
                     w_hold_nxt  = r_hold_cnt + 1'b1;
                  end
               end
            end

            ST_HELD: begin
               if (w_db_fall) begin
                  w_release_nxt = 1'b1;
                  w_state_nxt   = ST_IDLE;
               end else if (REPEAT_EN && w_tick) begin
                  if (r_hold_cnt == REP_LAST) begin
                     w_repeat_nxt = 1'b1;
                     w_hold_nxt   = '0;
                  end else begin
                     w_hold_nxt   = r_hold_cnt + 1'b1;
                  end
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
            end
         endcase
      end

      assign o_key[g]         = r_key;
      assign o_key_press[g]   = r_press;
      assign o_key_release[g] = r_release;
      assign o_key_long[g]    = r_long;
      assign o_key_repeat[g]  = r_repeat;
   end

endmodule

// File: tb/tb_key_check_array.sv
// ---------------------------------------------------------------------------
// tb_key_check_array
// Drives the same pins into two instances (auto-repeat enabled and disabled)
// and compares every cycle against a millisecond-level reference model:
// the model counts ticks since the synchronised level last changed and
// total ticks since a press, and derives long/repeat events arithmetically.
// Directed scenarios add pulse-count and latency checks on top.
// ---------------------------------------------------------------------------
module tb_key_check_array;

   localparam int CF = 1;
   localparam int KN = 4;
   localparam int DB = 2;
   localparam int LG = 4;
   localparam int RP = 2;
   localparam bit AL = 1'b1;
   localparam int MS = CF * 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [KN-1:0] i_key = '1;

   logic [KN-1:0] key_r, press_r, rel_r, long_r, rep_r;
   logic [KN-1:0] key_n, press_n, rel_n, long_n, rep_n;

   always #5 clk = ~clk;

   key_check_array #(
      .CLK_FRAC(CF), .KEY_NUM(KN), .DEBOUNCE_MS(DB),
      .LONG_MS(LG), .REPEAT_MS(RP), .ACTIVE_LOW(AL)
   ) dut_r (
      .clk(clk), .rst(rst), .i_key(i_key),
      .o_key(key_r), .o_key_press(press_r), .o_key_release(rel_r),
      .o_key_long(long_r), .o_key_repeat(rep_r)
   );

   key_check_array #(
      .CLK_FRAC(CF), .KEY_NUM(KN), .DEBOUNCE_MS(DB),
      .LONG_MS(LG), .REPEAT_MS(0), .ACTIVE_LOW(AL)
   ) dut_n (
      .clk(clk), .rst(rst), .i_key(i_key),
      .o_key(key_n), .o_key_press(press_n), .o_key_release(rel_n),
      .o_key_long(long_n), .o_key_repeat(rep_n)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   int            m_tcnt;
   logic [KN-1:0] m_s1, m_s2;
   logic [KN-1:0] m_lvl;
   int            m_stab [KN];
   int            m_hold [2][KN];
   logic [KN-1:0] m_pr [2];
   logic [KN-1:0] m_rl [2];
   logic [KN-1:0] m_lg [2];
   logic [KN-1:0] m_rp [2];
   bit            m_tick, m_rise, m_fall, m_down;
   int            m_rep_ms;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tcnt = 0;
         m_s1   = {KN{AL}};
         m_s2   = {KN{AL}};
         m_lvl  = '0;
         for (int v = 0; v < 2; v++) begin
            m_pr[v] = '0; m_rl[v] = '0; m_lg[v] = '0; m_rp[v] = '0;
            for (int k = 0; k < KN; k++) m_hold[v][k] = 0;
         end
         for (int k = 0; k < KN; k++) m_stab[k] = 0;
      end else begin
         m_tick = (m_tcnt == MS - 1);
         m_tcnt = m_tick ? 0 : m_tcnt + 1;
         for (int k = 0; k < KN; k++) begin
            m_down = (m_s2[k] != AL);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_down == m_lvl[k]) begin
               m_stab[k] = 0;
            end else if (m_tick) begin
               m_stab[k]++;
               if (m_stab[k] == DB) begin
                  m_lvl[k]  = ~m_lvl[k];
                  m_stab[k] = 0;
                  m_rise    = m_lvl[k];
                  m_fall    = !m_lvl[k];
               end
            end
            for (int v = 0; v < 2; v++) begin
               m_rep_ms   = (v == 0) ? RP : 0;
               m_pr[v][k] = m_rise;
               m_rl[v][k] = m_fall;
               m_lg[v][k] = 1'b0;
               m_rp[v][k] = 1'b0;
               if (m_rise) begin
                  m_hold[v][k] = 0;
               end else if (m_lvl[k] && m_tick) begin
                  m_hold[v][k]++;
                  if (m_hold[v][k] == LG)
                     m_lg[v][k] = 1'b1;
                  else if (m_rep_ms > 0 && m_hold[v][k] > LG &&
                           ((m_hold[v][k] - LG) % m_rep_ms) == 0)
                     m_rp[v][k] = 1'b1;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = i_key;
      end
   end

   // ---------------- monitor ----------------
   int c_press [KN], c_rel [KN], c_long [KN], c_rep [KN];
   int c_long_n [KN], c_rep_n [KN];
   int last_press [KN];

   initial begin
      for (int k = 0; k < KN; k++) begin
         c_press[k] = 0; c_rel[k] = 0; c_long[k] = 0; c_rep[k] = 0;
         c_long_n[k] = 0; c_rep_n[k] = 0; last_press[k] = 0;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         check_val("cycle_rep_on", {key_r, press_r, rel_r, long_r, rep_r},
                   {m_lvl, m_pr[0], m_rl[0], m_lg[0], m_rp[0]});
         check_val("cycle_rep_off", {key_n, press_n, rel_n, long_n, rep_n},
                   {m_lvl, m_pr[1], m_rl[1], m_lg[1], m_rp[1]});
         for (int k = 0; k < KN; k++) begin
            if (press_r[k] === 1'b1) begin c_press[k]++; last_press[k] = cyc; end
            if (rel_r[k]   === 1'b1) c_rel[k]++;
            if (long_r[k]  === 1'b1) c_long[k]++;
            if (rep_r[k]   === 1'b1) c_rep[k]++;
            if (long_n[k]  === 1'b1) c_long_n[k]++;
            if (rep_n[k]   === 1'b1) c_rep_n[k]++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int s_press [KN], s_rel [KN], s_long [KN], s_rep [KN], s_long_n [KN], s_rep_n [KN];

   task automatic snap();
      for (int k = 0; k < KN; k++) begin
         s_press[k] = c_press[k]; s_rel[k] = c_rel[k];
         s_long[k] = c_long[k];   s_rep[k] = c_rep[k];
         s_long_n[k] = c_long_n[k]; s_rep_n[k] = c_rep_n[k];
      end
   endtask

   // Leaves the caller 2 ns after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic lat_ok(input int lat);
      return (lat >= (DB - 1) * MS + 2) && (lat <= DB * MS + 3);
   endfunction

   task automatic run_long(input string tag, input int hold_cyc,
                           input int exp_long, input int exp_rep);
      snap();
      i_key[2] = 1'b0;
      step(hold_cyc);
      i_key[2] = 1'b1;
      step(2500);
      check_val({tag, "_press"},   c_press[2] - s_press[2], 1);
      check_val({tag, "_long"},    c_long[2] - s_long[2], exp_long);
      check_val({tag, "_repeat"},  c_rep[2] - s_rep[2], exp_rep);
      check_val({tag, "_release"}, c_rel[2] - s_rel[2], 1);
      check_val({tag, "_long_n"},  c_long_n[2] - s_long_n[2], exp_long);
      check_val({tag, "_rep_n"},   c_rep_n[2] - s_rep_n[2], 0);
      check_val({tag, "_level"},   key_r[2], 1'b0);
   endtask

   initial begin
      #(1500000);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   int c0, tot;

   initial begin
      // 1. reset, idle pins
      i_key = '1;
      #1 rst = 1'b1;
      step(10);
      rst = 1'b0;
      snap();
      step(3000);
      check_val("s1_key_r", key_r, '0);
      check_val("s1_key_n", key_n, '0);
      tot = 0;
      for (int k = 0; k < KN; k++)
         tot += (c_press[k] - s_press[k]) + (c_rel[k] - s_rel[k]) +
                (c_long[k] - s_long[k]) + (c_rep[k] - s_rep[k]);
      check_val("s1_pulses", tot, 0);

      // 2. clean press on ch0
      snap();
      c0 = cyc;
      i_key[0] = 1'b0;
      step(3000);
      check_val("s2_level", key_r[0], 1'b1);
      check_val("s2_press", c_press[0] - s_press[0], 1);
      check_val("s2_latency", lat_ok(last_press[0] - c0), 1'b1);
      i_key[0] = 1'b1;
      step(2500);
      check_val("s2_release", c_rel[0] - s_rel[0], 1);
      check_val("s2_long", c_long[0] - s_long[0], 0);
      check_val("s2_level_off", key_r[0], 1'b0);

      // 3. bouncing ch1, then held
      snap();
      for (int i = 0; i < 6; i++) begin
         i_key[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(700);
      end
      c0 = cyc;
      i_key[1] = 1'b0;
      step(2500);
      check_val("s3_press", c_press[1] - s_press[1], 1);
      check_val("s3_latency", lat_ok(last_press[1] - c0), 1'b1);
      check_val("s3_release", c_rel[1] - s_rel[1], 0);
      i_key[1] = 1'b1;
      step(2500);

      // 4. long press / repeat on ch2, including release-collision cases
      run_long("s4_hold11", 11000, 1, 3);
      run_long("s4_hold10", 10000, 1, 2);
      run_long("s4_hold4",  4000,  0, 0);

      // 5. simultaneous press, then reset while held
      snap();
      c0 = cyc;
      i_key[0] = 1'b0;
      i_key[3] = 1'b0;
      step(2500);
      check_val("s5_press0", c_press[0] - s_press[0], 1);
      check_val("s5_press3", c_press[3] - s_press[3], 1);
      check_val("s5_lat0", lat_ok(last_press[0] - c0), 1'b1);
      check_val("s5_lat3", lat_ok(last_press[3] - c0), 1'b1);
      #1 rst = 1'b1;
      #1;
      check_val("s5_rst_key_r", key_r, '0);
      check_val("s5_rst_key_n", key_n, '0);
      step(10);
      rst = 1'b0;
      c0 = cyc;
      step(2500);
      check_val("s5_repress0", c_press[0] - s_press[0], 2);
      check_val("s5_repress3", c_press[3] - s_press[3], 2);
      check_val("s5_relat0", lat_ok(last_press[0] - c0), 1'b1);
      check_val("s5_no_rel0", c_rel[0] - s_rel[0], 0);
      check_val("s5_no_rel3", c_rel[3] - s_rel[3], 0);
      i_key = '1;
      step(2500);
      check_val("s5_rel0", c_rel[0] - s_rel[0], 1);
      check_val("s5_rel3", c_rel[3] - s_rel[3], 1);

      // 6. random pin activity, checked cycle by cycle against the model
      for (int i = 0; i < 12; i++) begin
         int k;
         k = $urandom_range(KN - 1, 0);
         i_key[k] = ~i_key[k];
         step($urandom_range(2500, 150));
      end
      i_key = '1;
      step(3000);
      check_val("s6_idle_r", key_r, '0);
      check_val("s6_idle_n", key_n, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
